// File: rtl/sdp_ram_sync_be.sv
// Simple dual-port synchronous RAM with per-byte write enables, 1/2-cycle
// registered read latency, selectable read-during-write and post-reset zero-fill.
module sdp_ram_sync_be #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int MEM_DEPTH      = 256,
   parameter int READ_LATENCY   = 1,
   parameter int WRITE_FIRST    = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cs,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    rvalid,
   output logic                    busy,
   output logic                    addr_err
);

   localparam int NB = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } state_t;

   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   logic                    idle;
   logic                    wr_in_range, rd_in_range;
   logic                    wr_en, rd_req, rd_hit, err_d;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    rd_valid_q;
   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic                    addr_err_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RESET_STATE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end
         end
         ST_IDLE: ;
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy        = (state_q == ST_CLEAR);
   assign idle        = (state_q == ST_IDLE);
   assign wr_in_range = ({1'b0, waddr} < DEPTH_W);
   assign rd_in_range = ({1'b0, raddr} < DEPTH_W);
   assign wr_en       = idle & cs & we & wr_in_range;
   assign rd_req      = idle & cs & re;
   assign rd_hit      = rd_req & rd_in_range;
   assign err_d       = idle & cs & ((we & ~wr_in_range) | (re & ~rd_in_range));

   // NOTE: the array has no reset; clearing it is done one word per cycle by
   // the CLEAR state so it still maps onto block RAM.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[clr_cnt_q] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Out-of-range reads return zero; a same-address write merges in its
   // enabled lanes only when write-first behaviour is selected.
   always_comb begin
      rd_word = '0;
      if (rd_hit) begin
         rd_word = mem[raddr];
         if ((WRITE_FIRST != 0) && wr_en && (waddr == raddr)) begin
            for (int i = 0; i < NB; i++) begin
               if (be[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         addr_err_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_req;
         addr_err_q <= err_d;
         if (rd_req) rd_data_q <= rd_word;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  out_valid_q;
         logic [DATA_WIDTH-1:0] out_data_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_valid_q <= 1'b0;
               out_data_q  <= '0;
            end else begin
               out_valid_q <= rd_valid_q;
               if (rd_valid_q) out_data_q <= rd_data_q;
            end
         end

         assign rvalid = out_valid_q;
         assign rdata  = out_data_q;
      end else begin : g_lat1
         assign rvalid = rd_valid_q;
         assign rdata  = rd_data_q;
      end
   endgenerate

   assign addr_err = addr_err_q;

endmodule
